trace_sequencer: RTL and testbench

Controller that replays the branch trace memory into the TAGE predictor. It steps `InstructionNumber` through the trace, waits out the trace memory's read latency, and presents each branch address to the predictor with a valid/ready handshake. It then returns the actual outcome as a one-cycle training update and keeps branch and misprediction counts for the run. It sits between the trace memory (address/outcome ROM) and the predictor top level.

---
 rtl/trace_sequencer_if.sv | 23 ++
 rtl/trace_sequencer.sv | 125 ++++++++++++
 tb/tb_trace_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_sequencer_if.sv
// Predictor-side handshake and training-update bundle for trace_sequencer.
// The master side is the sequencer; the slave side is the predictor.
interface trace_sequencer_if #(
  parameter int ADDRESS_SIZE = 8
);
  logic                    PredValid;
  logic [ADDRESS_SIZE-1:0] PredAddress;
  logic                    PredReady;
  logic                    Prediction;
  logic                    UpdateValid;
  logic                    UpdateTaken;
  logic                    UpdateMispredict;

  modport master (
    output PredValid, PredAddress, UpdateValid, UpdateTaken, UpdateMispredict,
    input  PredReady, Prediction
  );

  modport slave (
    input  PredValid, PredAddress, UpdateValid, UpdateTaken, UpdateMispredict,
    output PredReady, Prediction
  );
endinterface

// File: rtl/trace_sequencer.sv
// Replays the branch trace ROM into the predictor one branch at a time,
// issues a training update per branch and counts branches/mispredictions.
module trace_sequencer #(
  parameter int ADDRESS_SIZE           = 8,
  parameter int TRAINING_DATA_SIZE     = 3898078,
  parameter int INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
  parameter int ROM_LATENCY            = 1
) (
  input  logic                              Clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              pause,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] InstructionNumber,
  input  logic [ADDRESS_SIZE-1:0]           TraceAddress,
  input  logic                              TraceResult,
  trace_sequencer_if.master                 pred,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       BranchCount,
  output logic [31:0]                       MispredictCount
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PREDICT,
    UPDATE,
    PAUSED,
    DONE
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(ROM_LATENCY - 1);
  localparam logic [INSTRUCTION_INDEX_SIZE-1:0] LAST_INDEX =
    INSTRUCTION_INDEX_SIZE'(TRAINING_DATA_SIZE - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       outcome_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state                 <= IDLE;
      wait_cnt              <= '0;
      outcome_q             <= 1'b0;
      InstructionNumber     <= '0;
      pred.PredValid        <= 1'b0;
      pred.PredAddress      <= '0;
      pred.UpdateValid      <= 1'b0;
      pred.UpdateTaken      <= 1'b0;
      pred.UpdateMispredict <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      BranchCount           <= '0;
      MispredictCount       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state             <= FETCH;
            wait_cnt          <= '0;
            InstructionNumber <= '0;
            BranchCount       <= '0;
            MispredictCount   <= '0;
            busy              <= 1'b1;
            done              <= 1'b0;
          end
        end

        // Address and outcome are captured on the last wait cycle so the
        // presented address stays frozen for the whole handshake.
        FETCH: begin
          if (wait_cnt == WAIT_LAST) begin
            state            <= PREDICT;
            wait_cnt         <= '0;
            pred.PredValid   <= 1'b1;
            pred.PredAddress <= TraceAddress;
            outcome_q        <= TraceResult;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        PREDICT: begin
          if (pred.PredReady) begin
            state                 <= UPDATE;
            pred.PredValid        <= 1'b0;
            pred.PredAddress      <= '0;
            pred.UpdateValid      <= 1'b1;
            pred.UpdateTaken      <= outcome_q;
            pred.UpdateMispredict <= pred.Prediction ^ outcome_q;
          end
        end

        UPDATE: begin
          pred.UpdateValid      <= 1'b0;
          pred.UpdateTaken      <= 1'b0;
          pred.UpdateMispredict <= 1'b0;
          if (BranchCount != '1) begin
            BranchCount <= BranchCount + 32'd1;
          end
          if (pred.UpdateMispredict && (MispredictCount != '1)) begin
            MispredictCount <= MispredictCount + 32'd1;
          end
          if (InstructionNumber == LAST_INDEX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            InstructionNumber <= InstructionNumber + 1'b1;
            state             <= pause ? PAUSED : FETCH;
          end
        end

        PAUSED: begin
          if (!pause) begin
            state <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_sequencer.sv
// Directed bench for trace_sequencer: a 4-entry trace replayed through a
// ROM_LATENCY=1 instance (with backpressure/pause/reset) and a ROM_LATENCY=3 one.
module tb_trace_sequencer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic reset, start, pause, start3;

  logic [7:0] mem_addr [0:3] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
  logic [3:0] mem_res = 4'b1101;  // entry0=1, entry1=0, entry2=1, entry3=1

  int checks   = 0;
  int failures = 0;

  // Latency-1 instance: combinational ROM lookup.
  logic [1:0]  idx1;
  logic [7:0]  ta1;
  logic        tr1;
  logic        busy1, done1;
  logic [31:0] bc1, mc1;
  trace_sequencer_if #(.ADDRESS_SIZE(8)) p1 ();

  assign ta1 = mem_addr[idx1];
  assign tr1 = mem_res[idx1];

  trace_sequencer #(
    .ADDRESS_SIZE(8),
    .TRAINING_DATA_SIZE(4),
    .ROM_LATENCY(1)
  ) dut1 (
    .Clk(Clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .InstructionNumber(idx1),
    .TraceAddress(ta1),
    .TraceResult(tr1),
    .pred(p1.master),
    .busy(busy1),
    .done(done1),
    .BranchCount(bc1),
    .MispredictCount(mc1)
  );

  // Latency-3 instance: two register stages after the lookup.
  logic [1:0]  idx3;
  logic [1:0]  s1 = 2'd0;
  logic [1:0]  s2 = 2'd0;
  logic [7:0]  ta3;
  logic        tr3;
  logic        busy3, done3;
  logic [31:0] bc3, mc3;
  logic        pause3;
  trace_sequencer_if #(.ADDRESS_SIZE(8)) p3 ();

  always_ff @(posedge Clk) begin
    s1 <= idx3;
    s2 <= s1;
  end
  assign ta3           = mem_addr[s2];
  assign tr3           = mem_res[s2];
  assign p3.PredReady  = 1'b1;
  assign p3.Prediction = 1'b0;
  assign pause3        = 1'b0;

  trace_sequencer #(
    .ADDRESS_SIZE(8),
    .TRAINING_DATA_SIZE(4),
    .ROM_LATENCY(3)
  ) dut3 (
    .Clk(Clk),
    .reset(reset),
    .start(start3),
    .pause(pause3),
    .InstructionNumber(idx3),
    .TraceAddress(ta3),
    .TraceResult(tr3),
    .pred(p3.master),
    .busy(busy3),
    .done(done3),
    .BranchCount(bc3),
    .MispredictCount(mc3)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start3 = 1'b0; pause = 1'b0;
    p1.PredReady = 1'b1; p1.Prediction = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++; if (idx1 !== 2'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", idx1); end
    checks++; if (p1.PredValid !== 1'b0) begin failures++; $display("FAIL reset_predvalid got=%b exp=0", p1.PredValid); end
    checks++; if (p1.PredAddress !== 8'h00) begin failures++; $display("FAIL reset_predaddr got=%h exp=00", p1.PredAddress); end
    checks++; if (p1.UpdateValid !== 1'b0) begin failures++; $display("FAIL reset_updvalid got=%b exp=0", p1.UpdateValid); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy1, done1); end
    checks++; if (bc1 !== 32'd0 || mc1 !== 32'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bc1, mc1); end
    checks++; if (busy3 !== 1'b0 || idx3 !== 2'd0 || p3.PredValid !== 1'b0) begin failures++; $display("FAIL reset_dut3 got busy=%b idx=%0d pv=%b exp 0/0/0", busy3, idx3, p3.PredValid); end
  endtask

  task automatic test_basic_run();
    int exp_mis;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      int k;
      int ph;
      k = i / 3;
      ph = i % 3;
      exp_mis = 0;
      for (int j = 0; j < k; j++) exp_mis += int'(mem_res[j]);
      checks++; if (idx1 !== 2'(k)) begin failures++; $display("FAIL basic_index cyc=%0d got=%0d exp=%0d", i, idx1, k); end
      checks++; if (p1.PredValid !== (ph == 1)) begin failures++; $display("FAIL basic_predvalid cyc=%0d got=%b exp=%b", i, p1.PredValid, ph == 1); end
      checks++; if (p1.UpdateValid !== (ph == 2)) begin failures++; $display("FAIL basic_updvalid cyc=%0d got=%b exp=%b", i, p1.UpdateValid, ph == 2); end
      checks++; if (bc1 !== 32'(k) || mc1 !== 32'(exp_mis)) begin failures++; $display("FAIL basic_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bc1, mc1, k, exp_mis); end
      checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin failures++; $display("FAIL basic_busy cyc=%0d got=%b%b exp=10", i, busy1, done1); end
      if (ph == 1) begin
        checks++; if (p1.PredAddress !== mem_addr[k]) begin failures++; $display("FAIL basic_predaddr cyc=%0d got=%h exp=%h", i, p1.PredAddress, mem_addr[k]); end
      end
      if (ph == 2) begin
        checks++; if (p1.UpdateTaken !== mem_res[k]) begin failures++; $display("FAIL basic_taken cyc=%0d got=%b exp=%b", i, p1.UpdateTaken, mem_res[k]); end
        checks++; if (p1.UpdateMispredict !== mem_res[k]) begin failures++; $display("FAIL basic_mispred cyc=%0d got=%b exp=%b", i, p1.UpdateMispredict, mem_res[k]); end
      end
      step();
    end
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL basic_done got=%b busy=%b exp=1/0", done1, busy1); end
    checks++; if (bc1 !== 32'd4 || mc1 !== 32'd3) begin failures++; $display("FAIL basic_final_counts got=%0d/%0d exp=4/3", bc1, mc1); end
    checks++; if (idx1 !== 2'd3) begin failures++; $display("FAIL basic_final_index got=%0d exp=3", idx1); end
  endtask

  task automatic test_restart();
    start = 1'b1; step(); start = 1'b0;
    checks++; if (bc1 !== 32'd0 || mc1 !== 32'd0) begin failures++; $display("FAIL restart_clear got=%0d/%0d exp=0/0", bc1, mc1); end
    checks++; if (idx1 !== 2'd0 || busy1 !== 1'b1 || done1 !== 1'b0) begin failures++; $display("FAIL restart_state got idx=%0d busy=%b done=%b exp 0/1/0", idx1, busy1, done1); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (idx1 !== 2'(i / 3)) begin failures++; $display("FAIL restart_index cyc=%0d got=%0d exp=%0d", i, idx1, i / 3); end
      start = (i == 4);  // mid-run start must be ignored
      step();
    end
    start = 1'b0;
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL restart_done got=%b exp=1", done1); end
    checks++; if (bc1 !== 32'd4 || mc1 !== 32'd3) begin failures++; $display("FAIL restart_counts got=%0d/%0d exp=4/3", bc1, mc1); end
  endtask

  task automatic test_backpressure();
    int upd = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      p1.PredReady = !(i >= 3 && i <= 7);
      if (i >= 4 && i <= 8) begin
        checks++; if (p1.PredValid !== 1'b1 || p1.PredAddress !== mem_addr[1]) begin failures++; $display("FAIL bp_hold cyc=%0d got pv=%b addr=%h exp 1/%h", i, p1.PredValid, p1.PredAddress, mem_addr[1]); end
      end
      if (i >= 3 && i <= 9 && p1.UpdateValid === 1'b1) upd++;
      if (i == 9) begin
        checks++; if (p1.UpdateValid !== 1'b1) begin failures++; $display("FAIL bp_update_cycle got=%b exp=1", p1.UpdateValid); end
      end
      if (i == 10) begin
        checks++; if (idx1 !== 2'd2 || p1.UpdateValid !== 1'b0) begin failures++; $display("FAIL bp_next_entry got idx=%0d uv=%b exp 2/0", idx1, p1.UpdateValid); end
      end
      step();
    end
    p1.PredReady = 1'b1;
    checks++; if (upd != 1) begin failures++; $display("FAIL bp_update_count got=%0d exp=1", upd); end
    checks++; if (done1 !== 1'b1 || bc1 !== 32'd4) begin failures++; $display("FAIL bp_done got done=%b bc=%0d exp 1/4", done1, bc1); end
  endtask

  task automatic test_pause();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pause = (i >= 2 && i <= 5);
      if (i >= 3 && i <= 6) begin
        checks++; if (busy1 !== 1'b1 || idx1 !== 2'd1 || p1.PredValid !== 1'b0 || p1.UpdateValid !== 1'b0) begin failures++; $display("FAIL pause_hold cyc=%0d got busy=%b idx=%0d pv=%b uv=%b exp 1/1/0/0", i, busy1, idx1, p1.PredValid, p1.UpdateValid); end
      end
      if (i == 7) begin
        checks++; if (p1.PredValid !== 1'b0) begin failures++; $display("FAIL pause_fetch got pv=%b exp=0", p1.PredValid); end
      end
      if (i == 8) begin
        checks++; if (p1.PredValid !== 1'b1 || p1.PredAddress !== mem_addr[1]) begin failures++; $display("FAIL pause_resume got pv=%b addr=%h exp 1/%h", p1.PredValid, p1.PredAddress, mem_addr[1]); end
      end
      step();
    end
    pause = 1'b0;
    checks++; if (done1 !== 1'b1 || bc1 !== 32'd4) begin failures++; $display("FAIL pause_done got done=%b bc=%0d exp 1/4", done1, bc1); end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++; if (p1.PredValid !== 1'b1 || idx1 !== 2'd2) begin failures++; $display("FAIL rst_mid_setup got pv=%b idx=%0d exp 1/2", p1.PredValid, idx1); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (p1.PredValid !== 1'b0 || p1.PredAddress !== 8'h00 || p1.UpdateValid !== 1'b0 || p1.UpdateTaken !== 1'b0 || p1.UpdateMispredict !== 1'b0) begin failures++; $display("FAIL rst_mid_pred got pv=%b pa=%h uv=%b ut=%b um=%b exp all 0", p1.PredValid, p1.PredAddress, p1.UpdateValid, p1.UpdateTaken, p1.UpdateMispredict); end
    checks++; if (idx1 !== 2'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || bc1 !== 32'd0 || mc1 !== 32'd0) begin failures++; $display("FAIL rst_mid_state got idx=%0d busy=%b done=%b bc=%0d mc=%0d exp all 0", idx1, busy1, done1, bc1, mc1); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (p1.UpdateValid !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL rst_mid_idle cyc=%0d got uv=%b busy=%b exp 0/0", i, p1.UpdateValid, busy1); end
      step();
    end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (idx1 !== 2'd0 || busy1 !== 1'b1) begin failures++; $display("FAIL rst_mid_restart got idx=%0d busy=%b exp 0/1", idx1, busy1); end
    step();
    checks++; if (p1.PredValid !== 1'b1 || p1.PredAddress !== mem_addr[0]) begin failures++; $display("FAIL rst_mid_first got pv=%b addr=%h exp 1/%h", p1.PredValid, p1.PredAddress, mem_addr[0]); end
    for (int i = 0; i < 11; i++) step();
    checks++; if (done1 !== 1'b1 || bc1 !== 32'd4 || mc1 !== 32'd3) begin failures++; $display("FAIL rst_mid_final got done=%b %0d/%0d exp 1 4/3", done1, bc1, mc1); end
  endtask

  task automatic test_latency3();
    start3 = 1'b1; step(); start3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      int k;
      int ph;
      k = i / 5;
      ph = i % 5;
      checks++; if (idx3 !== 2'(k)) begin failures++; $display("FAIL lat3_index cyc=%0d got=%0d exp=%0d", i, idx3, k); end
      checks++; if (p3.PredValid !== (ph == 3) || p3.UpdateValid !== (ph == 4)) begin failures++; $display("FAIL lat3_phase cyc=%0d got pv=%b uv=%b exp %b/%b", i, p3.PredValid, p3.UpdateValid, ph == 3, ph == 4); end
      if (ph == 3) begin
        checks++; if (p3.PredAddress !== mem_addr[k]) begin failures++; $display("FAIL lat3_predaddr cyc=%0d got=%h exp=%h", i, p3.PredAddress, mem_addr[k]); end
      end
      if (ph == 4) begin
        checks++; if (p3.UpdateTaken !== mem_res[k]) begin failures++; $display("FAIL lat3_taken cyc=%0d got=%b exp=%b", i, p3.UpdateTaken, mem_res[k]); end
      end
      step();
    end
    checks++; if (done3 !== 1'b1 || bc3 !== 32'd4 || mc3 !== 32'd3) begin failures++; $display("FAIL lat3_final got done=%b %0d/%0d exp 1 4/3", done3, bc3, mc3); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_restart();
    test_backpressure();
    test_pause();
    test_reset_midrun();
    test_latency3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
